tlb_assoc_mp: RTL and testbench

//  Parametrised fully-associative unified TLB with N entries, ASID tagging, a

---
 rtl/tlb_assoc_mp_pkg.sv | 26 ++
 rtl/tlb_match_prio.sv | 42 ++++
 rtl/tlb_assoc_mp.sv | 152 +++++++++++++++
 tb/tb_tlb_assoc_mp.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/tlb_assoc_mp_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tlb_assoc_mp_pkg : PTE flag layout and helpers for tlb_assoc_mp   |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package tlb_assoc_mp_pkg;

  localparam int c_PTE_G  = 0;
  localparam int c_PTE_V  = 1;
  localparam int c_PTE_D  = 2;
  localparam int c_PTE_C  = 3;
  localparam int c_FLAG_W = 4;

  function automatic logic [c_FLAG_W-1:0] pte_flags(input logic c, input logic d,
                                                   input logic v, input logic g);
    logic [c_FLAG_W-1:0] f;
    f          = '0;
    f[c_PTE_C] = c;
    f[c_PTE_D] = d;
    f[c_PTE_V] = v;
    f[c_PTE_G] = g;
    return f;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tlb_match_prio.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tlb_match_prio : match vector -> hit, lowest index, multi-hit     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tlb_match_prio #(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4
) (
  input  logic [ENTRIES-1:0] i_match,
  output logic               o_hit,
  output logic [IDX_W-1:0]   o_idx,
  output logic               o_multi
);

  logic             w_found;
  logic             w_multi;
  logic [IDX_W-1:0] w_idx;

  // o_idx stays 0 when nothing matches; probe_res relies on that.
  always_comb begin
    w_found = 1'b0;
    w_multi = 1'b0;
    w_idx   = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      if (i_match[i]) begin
        if (w_found) begin
          w_multi = 1'b1;
        end else begin
          w_found = 1'b1;
          w_idx   = IDX_W'(i);
        end
      end
    end
  end

  assign o_hit   = w_found;
  assign o_idx   = w_idx;
  assign o_multi = w_multi;

endmodule
`default_nettype wire

// File: rtl/tlb_assoc_mp.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tlb_assoc_mp : fully-associative multi-port TLB, ASID/global tags |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tlb_assoc_mp
  import tlb_assoc_mp_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int NPORTS  = 2,
  parameter int VPN_W   = 20,
  parameter int PFN_W   = 20,
  parameter int ASID_W  = 6,
  parameter int IDX_W   = $clog2(ENTRIES),
  parameter int PTE_W   = PFN_W + c_FLAG_W
) (
  input  logic                    clk,
  input  logic                    clrn,
  input  logic [NPORTS*VPN_W-1:0] l_vpn,
  input  logic [ASID_W-1:0]       cur_asid,
  output logic [NPORTS-1:0]       l_hit,
  output logic [NPORTS*PTE_W-1:0] l_pte,
  output logic [NPORTS-1:0]       l_multi,
  input  logic [VPN_W-1:0]        w_vpn,
  input  logic [ASID_W-1:0]       w_asid,
  input  logic [PTE_W-1:0]        w_pte,
  input  logic [IDX_W-1:0]        w_index,
  input  logic                    tlbwi,
  input  logic                    tlbwr,
  input  logic                    tlbp,
  input  logic                    inv_all,
  input  logic                    wired_we,
  input  logic [IDX_W-1:0]        wired_in,
  input  logic                    freeze,
  output logic [IDX_W-1:0]        random,
  output logic [IDX_W-1:0]        wired,
  output logic [IDX_W:0]          probe_res,
  output logic                    probe_vld
);

  localparam logic [IDX_W-1:0] c_LAST = IDX_W'(ENTRIES - 1);
  localparam logic [IDX_W:0]   c_NUM  = (IDX_W+1)'(ENTRIES);

  logic [VPN_W-1:0]  r_vpn  [ENTRIES];
  logic [ASID_W-1:0] r_asid [ENTRIES];
  logic [PTE_W-1:0]  r_pte  [ENTRIES];
  logic [ENTRIES-1:0] r_valid;
  logic [IDX_W-1:0]  r_random;
  logic [IDX_W-1:0]  r_wired;
  logic [IDX_W:0]    r_probe_res;
  logic              r_probe_vld;

  logic              w_wr_en;
  logic [IDX_W-1:0]  w_wr_idx;
  logic [ENTRIES-1:0] w_p_match;
  logic              w_p_hit;
  logic [IDX_W-1:0]  w_p_idx;

  for (genvar k = 0; k < NPORTS; k++) begin : g_port
    logic [ENTRIES-1:0] w_match;
    logic               w_hit;
    logic               w_multi;
    logic [IDX_W-1:0]   w_idx;

    always_comb begin
      w_match = '0;
      for (int i = 0; i < ENTRIES; i++) begin
        w_match[i] = r_valid[i] && (r_vpn[i] == l_vpn[k*VPN_W +: VPN_W]) &&
                     (r_pte[i][c_PTE_G] || (r_asid[i] == cur_asid));
      end
    end

    tlb_match_prio #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) u_prio (
      .i_match (w_match),
      .o_hit   (w_hit),
      .o_idx   (w_idx),
      .o_multi (w_multi)
    );

    assign l_hit[k]                 = w_hit;
    assign l_multi[k]               = w_multi;
    assign l_pte[k*PTE_W +: PTE_W]  = w_hit ? r_pte[w_idx] : '0;
  end

  always_comb begin
    w_p_match = '0;
    for (int i = 0; i < ENTRIES; i++) begin
      w_p_match[i] = r_valid[i] && (r_vpn[i] == w_vpn) &&
                     (r_pte[i][c_PTE_G] || (r_asid[i] == w_asid));
    end
  end

  tlb_match_prio #(.ENTRIES(ENTRIES), .IDX_W(IDX_W)) u_probe_prio (
    .i_match (w_p_match),
    .o_hit   (w_p_hit),
    .o_idx   (w_p_idx),
    .o_multi ()
  );

  // tlbwi has priority; an out-of-range index silently drops the write.
  always_comb begin
    w_wr_idx = tlbwi ? w_index : r_random;
    w_wr_en  = tlbwi ? ({1'b0, w_index} < c_NUM) : tlbwr;
  end

  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_vpn[w_wr_idx]  <= w_vpn;
      r_asid[w_wr_idx] <= w_asid;
      r_pte[w_wr_idx]  <= w_pte;
    end
  end

  // Write after clear so an entry written alongside inv_all survives.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_valid <= '0;
    end else begin
      if (inv_all) r_valid <= '0;
      if (w_wr_en) r_valid[w_wr_idx] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_random <= c_LAST;
      r_wired  <= '0;
    end else if (wired_we) begin
      r_wired  <= (wired_in > c_LAST) ? c_LAST : wired_in;
      r_random <= c_LAST;
    end else if (!freeze) begin
      r_random <= (r_random <= r_wired) ? c_LAST : r_random - IDX_W'(1);
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_probe_res <= '0;
      r_probe_vld <= 1'b0;
    end else begin
      r_probe_vld <= tlbp;
      if (tlbp) r_probe_res <= {~w_p_hit, w_p_idx};
    end
  end

  assign random    = r_random;
  assign wired     = r_wired;
  assign probe_res = r_probe_res;
  assign probe_vld = r_probe_vld;

endmodule
`default_nettype wire

// File: tb/tb_tlb_assoc_mp.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_tlb_assoc_mp : directed scoreboard bench for tlb_assoc_mp      |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_tlb_assoc_mp;
  import tlb_assoc_mp_pkg::*;

  localparam int NPORTS = 2;
  localparam int VPN_W  = 20;
  localparam int ASID_W = 6;
  localparam int IDX_W  = 4;
  localparam int PTE_W  = 24;

  logic                    clk = 1'b0;
  logic                    clrn;
  logic [NPORTS*VPN_W-1:0] l_vpn;
  logic [ASID_W-1:0]       cur_asid;
  logic [VPN_W-1:0]        w_vpn;
  logic [ASID_W-1:0]       w_asid;
  logic [PTE_W-1:0]        w_pte;
  logic [IDX_W-1:0]        w_index;
  logic                    tlbwi, tlbwr, tlbp, inv_all, wired_we, freeze;
  logic [IDX_W-1:0]        wired_in;

  logic [NPORTS-1:0]       l_hit, l_multi, b_hit, b_multi;
  logic [NPORTS*PTE_W-1:0] l_pte, b_pte;
  logic [IDX_W-1:0]        random, wired, b_random, b_wired;
  logic [IDX_W:0]          probe_res, b_probe_res;
  logic                    probe_vld, b_probe_vld;

  always #5 clk = ~clk;

  tlb_assoc_mp #(.ENTRIES(16)) dut (
    .clk(clk), .clrn(clrn), .l_vpn(l_vpn), .cur_asid(cur_asid),
    .l_hit(l_hit), .l_pte(l_pte), .l_multi(l_multi),
    .w_vpn(w_vpn), .w_asid(w_asid), .w_pte(w_pte), .w_index(w_index),
    .tlbwi(tlbwi), .tlbwr(tlbwr), .tlbp(tlbp), .inv_all(inv_all),
    .wired_we(wired_we), .wired_in(wired_in), .freeze(freeze),
    .random(random), .wired(wired), .probe_res(probe_res), .probe_vld(probe_vld)
  );

  // Non-power-of-two instance for the clamp and dropped-index boundaries.
  tlb_assoc_mp #(.ENTRIES(12)) dut12 (
    .clk(clk), .clrn(clrn), .l_vpn(l_vpn), .cur_asid(cur_asid),
    .l_hit(b_hit), .l_pte(b_pte), .l_multi(b_multi),
    .w_vpn(w_vpn), .w_asid(w_asid), .w_pte(w_pte), .w_index(w_index),
    .tlbwi(tlbwi), .tlbwr(tlbwr), .tlbp(tlbp), .inv_all(inv_all),
    .wired_we(wired_we), .wired_in(wired_in), .freeze(freeze),
    .random(b_random), .wired(b_wired), .probe_res(b_probe_res), .probe_vld(b_probe_vld)
  );

  typedef struct {
    string       tag;
    logic [63:0] exp;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic sb_push(input string tag, input logic [63:0] exp);
    exp_t e;
    e.tag = tag;
    e.exp = exp;
    sb.push_back(e);
  endtask

  task automatic sb_check(input logic [63:0] obs);
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      failures++;
      $error("FAIL scoreboard_empty observed=%0h expected=none", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.exp) else begin
        failures++;
        $error("FAIL %s observed=%0h expected=%0h", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic expect_now(input string tag, input logic [63:0] exp, input logic [63:0] obs);
    sb_push(tag, exp);
    sb_check(obs);
  endtask

  function automatic logic [PTE_W-1:0] mk(input logic [19:0] pfn, input logic g);
    return {pfn, pte_flags(1'b0, 1'b0, 1'b1, g)};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic look(input int port, input logic [VPN_W-1:0] vpn, input logic [ASID_W-1:0] asid);
    l_vpn[port*VPN_W +: VPN_W] = vpn;
    cur_asid = asid;
    #1;
  endtask

  task automatic wr(input logic wi, input logic wrr, input logic [IDX_W-1:0] idx,
                    input logic [VPN_W-1:0] vpn, input logic [ASID_W-1:0] asid,
                    input logic [PTE_W-1:0] p);
    w_vpn = vpn; w_asid = asid; w_pte = p; w_index = idx;
    tlbwi = wi; tlbwr = wrr;
    tick();
    tlbwi = 1'b0; tlbwr = 1'b0;
  endtask

  task automatic probe(input logic [VPN_W-1:0] vpn, input logic [ASID_W-1:0] asid);
    w_vpn = vpn; w_asid = asid; tlbp = 1'b1;
    tick();
    tlbp = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [IDX_W-1:0] exp_r;
    clrn = 1'b0; l_vpn = '0; cur_asid = '0; w_vpn = '0; w_asid = '0; w_pte = '0;
    w_index = '0; tlbwi = 0; tlbwr = 0; tlbp = 0; inv_all = 0; wired_we = 0;
    wired_in = '0; freeze = 1'b1;
    tick(); tick();

    expect_now("rst_random", 15, random);
    expect_now("rst_random12", 11, b_random);
    expect_now("rst_wired", 0, wired);
    expect_now("rst_hit", 0, l_hit);
    expect_now("rst_multi", 0, l_multi);
    expect_now("rst_probe_vld", 0, probe_vld);
    expect_now("rst_probe_res", 0, probe_res);
    clrn = 1'b1;
    tick();

    // Indexed write; lookup in the write cycle still sees the old contents.
    w_vpn = 20'h12345; w_asid = 6'd5; w_pte = mk(20'hABCDE, 1'b0); w_index = 4'd3; tlbwi = 1'b1;
    look(1, 20'h12345, 6'd5);
    expect_now("hit_in_write_cycle", 0, l_hit[1]);
    tick();
    tlbwi = 1'b0;
    sb_push("hit_asid5", 1); sb_push("pte_asid5", mk(20'hABCDE, 1'b0));
    sb_check(l_hit[1]); sb_check(l_pte[PTE_W +: PTE_W]);
    look(1, 20'h12345, 6'd6);
    sb_push("hit_asid6", 0); sb_push("pte_miss_zero", 0);
    sb_check(l_hit[1]); sb_check(l_pte[PTE_W +: PTE_W]);
    wr(1, 0, 4'd3, 20'h12345, 6'd5, mk(20'hABCDE, 1'b1));
    look(1, 20'h12345, 6'd6);
    sb_push("hit_global", 1); sb_push("pte_global", mk(20'hABCDE, 1'b1));
    sb_check(l_hit[1]); sb_check(l_pte[PTE_W +: PTE_W]);

    // Wired load under freeze, then the Random walk.
    wired_in = 4'd4; wired_we = 1'b1;
    tick();
    wired_we = 1'b0;
    expect_now("wired_4", 4, wired);
    expect_now("random_forced", 15, random);
    freeze = 1'b0;
    exp_r = 4'd15;
    for (int i = 0; i < 20; i++) begin
      expect_now("random_seq", exp_r, random);
      tick();
      exp_r = (exp_r <= 4'd4) ? 4'd15 : exp_r - 4'd1;
    end
    freeze = 1'b1;
    expect_now("random_before_freeze", exp_r, random);
    tick(); tick(); tick();
    expect_now("random_frozen", exp_r, random);

    wired_in = 4'd14; wired_we = 1'b1;
    tick();
    wired_we = 1'b0;
    expect_now("wired_14", 14, wired);
    expect_now("wired_clamp12", 11, b_wired);
    expect_now("random_clamp12", 11, b_random);
    wired_in = 4'd15; wired_we = 1'b1;
    tick();
    expect_now("wired_max", 15, wired);
    expect_now("random_max", 15, random);
    wired_in = 4'd0;
    tick();
    wired_we = 1'b0;
    expect_now("wired_zero", 0, wired);

    // Index 13 is legal at 16 entries but out of range at 12.
    wr(1, 0, 4'd13, 20'h0DDDD, 6'd0, mk(20'h0DDDD, 1'b1));
    look(0, 20'h0DDDD, 6'd0);
    expect_now("idx13_written", 1, l_hit[0]);
    expect_now("idx13_dropped12", 0, b_hit[0]);

    // Duplicate VPN: lowest index wins, multi flagged; probe reports idx 2.
    wr(1, 0, 4'd2, 20'h55555, 6'd1, mk(20'h22222, 1'b1));
    wr(1, 0, 4'd7, 20'h55555, 6'd1, mk(20'h77777, 1'b1));
    look(0, 20'h55555, 6'd0);
    look(1, 20'h12345, 6'd0);
    expect_now("dup_hit", 2'b11, l_hit);
    expect_now("dup_pte_low", mk(20'h22222, 1'b1), l_pte[0 +: PTE_W]);
    expect_now("dup_multi", 2'b01, l_multi);
    probe(20'h55555, 6'd1);
    expect_now("probe_vld", 1, probe_vld);
    expect_now("probe_dup_idx", 5'h02, probe_res);
    tick();
    expect_now("probe_vld_pulse", 0, probe_vld);
    expect_now("probe_res_hold", 5'h02, probe_res);

    // Invalidate-all with a same-cycle write.
    inv_all = 1'b1;
    wr(1, 0, 4'd9, 20'h99999, 6'd0, mk(20'h00099, 1'b1));
    inv_all = 1'b0;
    look(0, 20'h99999, 6'd0);
    look(1, 20'h55555, 6'd1);
    expect_now("inv_only_idx9", 2'b01, l_hit);
    look(1, 20'h0DDDD, 6'd0);
    expect_now("inv_idx13", 0, l_hit[1]);
    probe(20'h00ABC, 6'd0);
    expect_now("probe_miss", 5'h10, probe_res);

    // tlbwi beats tlbwr; the Random slot (15) keeps its contents.
    wr(1, 0, 4'd15, 20'hF0F0F, 6'd0, mk(20'hF0F0F, 1'b1));
    wr(1, 1, 4'd5, 20'h0B0B0, 6'd0, mk(20'h0000B, 1'b1));
    look(0, 20'hF0F0F, 6'd0);
    look(1, 20'h0B0B0, 6'd0);
    expect_now("slot15_kept", mk(20'hF0F0F, 1'b1), l_pte[0 +: PTE_W]);
    expect_now("wi_wins", mk(20'h0000B, 1'b1), l_pte[PTE_W +: PTE_W]);
    probe(20'h0B0B0, 6'd0);
    expect_now("probe_wi_only", 5'h05, probe_res);

    // tlbwr alone targets Random.
    wr(0, 1, 4'd0, 20'h3C3C3, 6'd2, mk(20'h3C3C3, 1'b0));
    probe(20'h3C3C3, 6'd2);
    expect_now("probe_tlbwr", 5'h0F, probe_res);
    look(0, 20'hF0F0F, 6'd0);
    expect_now("tlbwr_replaced", 0, l_hit[0]);

    // Probe alongside a write sees pre-edge contents.
    w_vpn = 20'h44444; w_asid = 6'd3; w_pte = mk(20'h44444, 1'b0); w_index = 4'd1;
    tlbwi = 1'b1; tlbp = 1'b1;
    tick();
    tlbwi = 1'b0; tlbp = 1'b0;
    expect_now("probe_old_contents", 5'h10, probe_res);
    look(0, 20'h44444, 6'd3);
    expect_now("probe_write_landed", 1, l_hit[0]);

    // Asynchronous reset mid-probe.
    wired_in = 4'd3; wired_we = 1'b1;
    tick();
    wired_we = 1'b0;
    w_vpn = 20'h99999; w_asid = 6'd0; tlbp = 1'b1;
    #2;
    clrn = 1'b0;
    #1;
    look(0, 20'h99999, 6'd0);
    expect_now("async_hit", 0, l_hit[0]);
    expect_now("async_wired", 0, wired);
    expect_now("async_random", 15, random);
    tick();
    tlbp = 1'b0;
    expect_now("async_probe_lost", 0, probe_vld);
    clrn = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
